ivl_uvm_ovl_fire_collector: RTL and testbench
=============================================

// Module: ivl_uvm_ovl_fire_collector
// PURPOSE
//  Sink for the `fire` outputs of up to NUM_CHK OVL checkers, e.g. ovl_proposition instances.
//  Samples each checker's fire[2:0] vector on every clock. Bit 0 = assert fail, bit 1 = X-check, bit 2 = cover.
//  Keeps per-checker fail counts, global totals and a record of the first failure.
//  Raises a stop request so the bench can call $finish after a failure budget is exhausted.
//  Sits beside the checkers in every OVL directed test.
// PARAMETERS
//  NUM_CHK      4   number of checkers attached (1..32)
//  CNT_W        8   width of per-checker and total counters; all counters saturate
//  CYC_W        16  width of the free-running cycle stamp; saturates at all-ones
//  STOP_THRESH  4   total fail count that enters HALT; 0 = never halt
// PORTS
//  clk          in   1            clock shared with the checkers
//  reset        in   1            asynchronous, active-low reset
//  enable       in   1            sampling enable; same polarity as the checkers' enable
//  clear        in   1            synchronous clear of all state and counters
//  fire_in      in   3*NUM_CHK    checker i drives bits [3i+2:3i]
//  rd_idx       in   $clog2(NUM_CHK)  checker index for counter readout
//  rd_cnt       out  CNT_W        fail count of rd_idx, registered
//  total_fail   out  CNT_W        sum of all fail events
//  cover_cnt    out  CNT_W        sum of all cover events
//  xchk_sticky  out  1            an X-check event has been seen
//  first_idx    out  $clog2(NUM_CHK)  checker that failed first
//  first_cyc    out  CYC_W        cycle stamp of the first fail
//  err_sticky   out  1            state is FAILED or HALT
//  stop_req     out  1            state is HALT
// BEHAVIOUR
//  - Reset (reset=0): every output and counter is 0 and the state is IDLE.
//  - Cycle stamp: counts clk edges while state != IDLE and enable=1. Cleared by clear.
//  - Sampling: fire_in is sampled only when enable=1 and the state is MONITOR or FAILED.
//    In IDLE and HALT, fire_in is ignored.
//  - Per checker with fail bit=1 in a sampled cycle: its count +1 and total_fail +1, both saturating.
//    Several checkers failing in the same cycle add their number to total_fail, clamped at saturation.
//  - Cover bits: summed into cover_cnt the same way as fails.
//  - X-check bits: any set bit sets xchk_sticky.
//  - First-fail capture happens on the first fail after reset or clear.
//    first_idx = lowest-numbered checker failing in that cycle.
//    first_cyc = cycle stamp of that cycle. Neither is overwritten afterwards.
//  - FSM transitions:
//      IDLE -> MONITOR on enable=1.
//      MONITOR -> FAILED on any sampled fail.
//      FAILED -> HALT when the next total_fail >= STOP_THRESH, and STOP_THRESH != 0.
//      MONITOR -> HALT directly if a single cycle reaches the threshold.
//      HALT is left only by clear or reset.
//  - enable=0 in MONITOR or FAILED: sampling is suspended; state and counters hold.
//  - clear=1 (any state): next cycle all counters, stamps and stickies are 0 and state is IDLE.
//    clear has priority over a fire in the same cycle.
//  - Outputs: err_sticky, stop_req and the counters are registered and update 1 cycle after the sampled edge.
//    rd_cnt reflects rd_idx one cycle later.
//  - rd_idx >= NUM_CHK: rd_cnt = 0.
// CONFIGURATION
//  IVL_UVM_OVL_FIRE_DISPLAY_EN
//  - Defined: each sampled fail prints $display("OVL FIRE chk=%0d cyc=%0d t=%0t").
//    Entry to HALT prints once.
//  - Undefined: no $display; RTL behaviour is identical.
// STRUCTURE
//  - Package ivl_uvm_ovl_fire_pkg holds:
//    fire bit localparams FIRE_ASSERT=0, FIRE_XCHK=1, FIRE_COVER=2;
//    FIRE_W=3;
//    typedef enum {IDLE, MONITOR, FAILED, HALT} fire_state_e.
//  - Sub-module ivl_uvm_ovl_fire_counter: CNT_W saturating counter with inc, clr and async reset.
//    Instantiated NUM_CHK times.
// TESTING
//  - Reset, then enable=1 with fire_in=0 for 20 cycles -> state MONITOR; all counts 0; err_sticky=0.
//  - Checker 2 fail for 1 cycle at stamp 5 -> next cycle: err_sticky=1, first_idx=2, first_cyc=5,
//    total_fail=1; reading rd_idx=2 gives rd_cnt=1.
//  - Checkers 1 and 3 fail in the same cycle, first fail since clear -> first_idx=1, total_fail +2.
//  - STOP_THRESH=4 with 4 fail cycles -> stop_req=1 after the 4th; further fails leave total_fail=4.
//  - CNT_W=2 with checker 0 failing for 6 cycles, STOP_THRESH=0 -> rd_cnt saturates at 3 and stop_req stays 0.
//  - clear pulse in HALT -> IDLE, all outputs 0.
//    Reset asserted mid-FAILED -> outputs 0 immediately, without waiting for a clock.
//  - Cover bit on checker 0 for 3 cycles -> cover_cnt=3 and err_sticky=0.

Source files
------------

// File: rtl/ivl_uvm_ovl_fire_pkg.sv
// Shared definitions for the OVL fire collector: fire-bit positions and FSM states.
// Pure declarations, no logic; no latency or flow control.
package ivl_uvm_ovl_fire_pkg;

    localparam int FIRE_ASSERT = 0;
    localparam int FIRE_XCHK   = 1;
    localparam int FIRE_COVER  = 2;
    localparam int FIRE_W      = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        FAILED  = 2'd2,
        HALT    = 2'd3
    } fire_state_e;

endpackage

// File: rtl/ivl_uvm_ovl_fire_counter.sv
// Saturating event counter with synchronous clear; count visible 1 cycle after inc.
// No backpressure: inc is accepted every cycle, and is dropped once the count is all-ones.
module ivl_uvm_ovl_fire_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// Collects OVL checker fire vectors into saturating counters and a first-fail record; outputs lag the sample by 1 cycle.
// No backpressure (fire_in is sampled every enabled cycle); IVL_UVM_OVL_FIRE_DISPLAY_EN adds simulation prints.
module ivl_uvm_ovl_fire_collector
    import ivl_uvm_ovl_fire_pkg::*;
#(
    parameter int  NUM_CHK     = 4,
    parameter int  CNT_W       = 8,
    parameter int  CYC_W       = 16,
    parameter int  STOP_THRESH = 4,
    localparam int IDX_W       = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [FIRE_W*NUM_CHK-1:0] fire_in,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [CNT_W-1:0]          rd_cnt,
    output logic [CNT_W-1:0]          total_fail,
    output logic [CNT_W-1:0]          cover_cnt,
    output logic                      xchk_sticky,
    output logic [IDX_W-1:0]          first_idx,
    output logic [CYC_W-1:0]          first_cyc,
    output logic                      err_sticky,
    output logic                      stop_req
);

    // Six spare bits hold a per-cycle event count of up to 32 checkers before clamping.
    localparam int               SUM_W   = CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    fire_state_e        state_q, state_d;
    logic [CNT_W-1:0]   total_q, total_d, cover_q, cover_d, rd_cnt_q, rd_cnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d, first_cyc_q, first_cyc_d;
    logic [IDX_W-1:0]   first_idx_q, first_idx_d, low_idx;
    logic               first_vld_q, first_vld_d, xchk_q, xchk_d;
    logic               sample, any_fail, any_xchk, halt_hit;
    logic [5:0]         fail_num, cover_num;
    logic [SUM_W-1:0]   total_sum, cover_sum;
    logic [NUM_CHK-1:0] fail_vec;
    logic [CNT_W-1:0]   chk_cnt [NUM_CHK];

    assign sample = enable && ((state_q == MONITOR) || (state_q == FAILED));

    // Descending scan so the lowest-numbered failing checker wins low_idx.
    always_comb begin
        fail_vec  = '0;
        fail_num  = '0;
        cover_num = '0;
        any_xchk  = 1'b0;
        low_idx   = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            fail_vec[i] = fire_in[FIRE_W*i + FIRE_ASSERT];
            fail_num    = fail_num + 6'(fire_in[FIRE_W*i + FIRE_ASSERT]);
            cover_num   = cover_num + 6'(fire_in[FIRE_W*i + FIRE_COVER]);
            any_xchk    = any_xchk | fire_in[FIRE_W*i + FIRE_XCHK];
            if (fire_in[FIRE_W*i + FIRE_ASSERT]) begin
                low_idx = IDX_W'(i);
            end
        end
        any_fail = |fail_vec;
    end

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        cover_d     = cover_q;
        xchk_d      = xchk_q;
        cyc_d       = cyc_q;
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;
        first_cyc_d = first_cyc_q;
        total_sum   = SUM_W'(total_q) + SUM_W'(fail_num);
        cover_sum   = SUM_W'(cover_q) + SUM_W'(cover_num);

        if (sample) begin
            total_d = (total_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : total_sum[CNT_W-1:0];
            cover_d = (cover_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cover_sum[CNT_W-1:0];
            xchk_d  = xchk_q | any_xchk;
            if (any_fail && !first_vld_q) begin
                first_vld_d = 1'b1;
                first_idx_d = low_idx;
                first_cyc_d = cyc_q;
            end
        end

        if ((state_q != IDLE) && enable && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        halt_hit = (STOP_THRESH != 0) && (32'(total_d) >= 32'(STOP_THRESH));

        case (state_q)
            IDLE:    if (enable) state_d = MONITOR;
            MONITOR: if (sample && any_fail) state_d = halt_hit ? HALT : FAILED;
            FAILED:  if (sample && halt_hit) state_d = HALT;
            default: state_d = state_q;
        endcase

        rd_cnt_d = (32'(rd_idx) < NUM_CHK) ? chk_cnt[rd_idx] : '0;

        if (clear) begin
            state_d     = IDLE;
            total_d     = '0;
            cover_d     = '0;
            xchk_d      = 1'b0;
            cyc_d       = '0;
            first_vld_d = 1'b0;
            first_idx_d = '0;
            first_cyc_d = '0;
            rd_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            total_q     <= '0;
            cover_q     <= '0;
            xchk_q      <= 1'b0;
            cyc_q       <= '0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
            first_cyc_q <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            cover_q     <= cover_d;
            xchk_q      <= xchk_d;
            cyc_q       <= cyc_d;
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
            first_cyc_q <= first_cyc_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_cnt
        ivl_uvm_ovl_fire_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .clr  (clear),
            .inc  (sample && fail_vec[g]),
            .cnt  (chk_cnt[g])
        );
    end

`ifdef IVL_UVM_OVL_FIRE_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (reset && !clear) begin
            if (sample) begin
                for (int i = 0; i < NUM_CHK; i++) begin
                    if (fail_vec[i]) $display("OVL FIRE chk=%0d cyc=%0d t=%0t", i, cyc_q, $time);
                end
            end
            if ((state_q != HALT) && (state_d == HALT)) $display("OVL FIRE HALT t=%0t", $time);
        end
    end
`endif

    assign rd_cnt      = rd_cnt_q;
    assign total_fail  = total_q;
    assign cover_cnt   = cover_q;
    assign xchk_sticky = xchk_q;
    assign first_idx   = first_idx_q;
    assign first_cyc   = first_cyc_q;
    assign err_sticky  = (state_q == FAILED) || (state_q == HALT);
    assign stop_req    = (state_q == HALT);

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// Bench for the OVL fire collector: default instance plus a CNT_W=2, STOP_THRESH=0 instance.
module tb_ivl_uvm_ovl_fire_collector;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        enable, clear;
    logic [11:0] fire_in;
    logic [1:0]  rd_idx;
    logic [7:0]  rd_cnt, total_fail, cover_cnt;
    logic        xchk_sticky, err_sticky, stop_req;
    logic [1:0]  first_idx;
    logic [15:0] first_cyc;

    logic        s_en, s_clr;
    logic [11:0] s_fire;
    logic [1:0]  s_idx, s_rd, s_tot, s_cov, s_fi;
    logic        s_x, s_err, s_stop;
    logic [15:0] s_fc;

    ivl_uvm_ovl_fire_collector dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .fire_in(fire_in),
        .rd_idx(rd_idx), .rd_cnt(rd_cnt), .total_fail(total_fail), .cover_cnt(cover_cnt),
        .xchk_sticky(xchk_sticky), .first_idx(first_idx), .first_cyc(first_cyc),
        .err_sticky(err_sticky), .stop_req(stop_req)
    );

    ivl_uvm_ovl_fire_collector #(.CNT_W(2), .STOP_THRESH(0)) dut_s (
        .clk(clk), .reset(reset), .enable(s_en), .clear(s_clr), .fire_in(s_fire),
        .rd_idx(s_idx), .rd_cnt(s_rd), .total_fail(s_tot), .cover_cnt(s_cov),
        .xchk_sticky(s_x), .first_idx(s_fi), .first_cyc(s_fc),
        .err_sticky(s_err), .stop_req(s_stop)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic [11:0] fire;
        logic [1:0]  idx;
        logic        err;
        logic        stop;
        logic [7:0]  tot;
        logic [7:0]  cov;
        logic        x;
        logic [1:0]  fi;
        logic [15:0] fc;
        logic [7:0]  rdc;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];
    int n_total = 0;
    int n_bad   = 0;

    function automatic vec_t mk(input logic en, input logic clr, input logic [11:0] fire,
                                input logic [1:0] idx, input logic err, input logic stop,
                                input logic [7:0] tot, input logic [7:0] cov, input logic x,
                                input logic [1:0] fi, input logic [15:0] fc, input logic [7:0] rdc);
        vec_t v;
        v.en = en; v.clr = clr; v.fire = fire; v.idx = idx;
        v.err = err; v.stop = stop; v.tot = tot; v.cov = cov;
        v.x = x; v.fi = fi; v.fc = fc; v.rdc = rdc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t e);
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(e.err));
        chk({tag, ".stop_req"}, 32'(stop_req), 32'(e.stop));
        chk({tag, ".total_fail"}, 32'(total_fail), 32'(e.tot));
        chk({tag, ".cover_cnt"}, 32'(cover_cnt), 32'(e.cov));
        chk({tag, ".xchk_sticky"}, 32'(xchk_sticky), 32'(e.x));
        chk({tag, ".first_idx"}, 32'(first_idx), 32'(e.fi));
        chk({tag, ".first_cyc"}, 32'(first_cyc), 32'(e.fc));
        chk({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(e.rdc));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t e;
        //      en clr fire    idx err stp tot cov x fi fc  rdc
        for (int i = 0; i < 6; i++) vt.push_back(mk(1, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 12'h040, 2, 1, 0, 1, 0, 0, 2, 5, 0));  // checker 2 fails at stamp 5
        vt.push_back(mk(1, 0, 12'h000, 2, 1, 0, 1, 0, 0, 2, 5, 1));
        vt.push_back(mk(0, 0, 12'h001, 0, 1, 0, 1, 0, 0, 2, 5, 0));  // enable low: ignored
        vt.push_back(mk(1, 0, 12'h424, 2, 1, 0, 1, 2, 1, 2, 5, 1));  // two covers, one X-check
        vt.push_back(mk(1, 0, 12'h208, 1, 1, 0, 3, 2, 1, 2, 5, 0));
        vt.push_back(mk(1, 0, 12'h000, 1, 1, 0, 3, 2, 1, 2, 5, 1));
        vt.push_back(mk(1, 0, 12'h001, 3, 1, 1, 4, 2, 1, 2, 5, 1));  // 4th fail -> HALT
        vt.push_back(mk(1, 0, 12'h249, 0, 1, 1, 4, 2, 1, 2, 5, 1));  // HALT ignores fires
        vt.push_back(mk(1, 1, 12'h249, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // clear in HALT
        vt.push_back(mk(1, 0, 12'h208, 3, 0, 0, 0, 0, 0, 0, 0, 0));  // IDLE ignores fires
        vt.push_back(mk(1, 0, 12'h208, 3, 1, 0, 2, 0, 0, 1, 0, 0));  // 1 and 3 together
        vt.push_back(mk(1, 0, 12'h000, 3, 1, 0, 2, 0, 0, 1, 0, 1));
        vt.push_back(mk(1, 1, 12'h001, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // clear beats a fire
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 12'h249, 0, 1, 1, 4, 0, 0, 0, 0, 0));  // MONITOR -> HALT in one cycle
        vt.push_back(mk(1, 0, 12'h249, 0, 1, 1, 4, 0, 0, 0, 0, 1));

        reset = 1'b0; enable = 1'b0; clear = 1'b0; fire_in = '0; rd_idx = '0;
        s_en = 1'b0; s_clr = 1'b0; s_fire = '0; s_idx = '0;
        repeat (3) @(negedge clk);
        chk_vec("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reset.s_tot", 32'(s_tot), 32'd0);
        reset = 1'b1;

        enable = 1'b1;
        repeat (20) step();
        chk_vec("monitor20", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        enable = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        chk_vec("clear0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            enable = vt[i].en; clear = vt[i].clr; fire_in = vt[i].fire; rd_idx = vt[i].idx;
            sb.push_back(vt[i]);
            step();
            if (sb.size() == 0) begin
                chk($sformatf("v%0d.scoreboard_empty", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk_vec($sformatf("v%0d", i), e);
            end
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Cover on checker 0 for three cycles never raises err_sticky.
        fire_in = '0; clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        fire_in = 12'h004;
        repeat (3) step();
        fire_in = '0;
        chk("cover.cover_cnt", 32'(cover_cnt), 32'd3);
        chk("cover.err_sticky", 32'(err_sticky), 32'd0);
        chk("cover.total_fail", 32'(total_fail), 32'd0);

        // Narrow instance: checker 0 fails six cycles, counters clamp at 3, never halts.
        s_en = 1'b1;
        step();
        s_fire = 12'h001;
        repeat (6) step();
        s_fire = '0;
        step();
        chk("sat.rd_cnt", 32'(s_rd), 32'd3);
        chk("sat.total_fail", 32'(s_tot), 32'd3);
        chk("sat.stop_req", 32'(s_stop), 32'd0);
        chk("sat.err_sticky", 32'(s_err), 32'd1);

        // Async reset while FAILED clears outputs without a clock edge.
        fire_in = 12'h001;
        step();
        fire_in = '0;
        chk("prerst.err_sticky", 32'(err_sticky), 32'd1);
        chk("prerst.total_fail", 32'(total_fail), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.err_sticky", 32'(err_sticky), 32'd0);
        chk("arst.total_fail", 32'(total_fail), 32'd0);
        chk("arst.cover_cnt", 32'(cover_cnt), 32'd0);
        chk("arst.s_rd_cnt", 32'(s_rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
